// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_alloc_pkg;

  localparam int unsigned NOTE_W       = 7;
  localparam int unsigned VOICE_NOTE_W = 8;

  localparam logic EV_OFF = 1'b0;
  localparam logic EV_ON  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit,
    StRetrig
  } alloc_state_e;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: holds the note, gate and saturating age of a single voice.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int unsigned AGE_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [NOTE_W-1:0]   load_note_i,
  input  logic                load_gate_i,
  input  logic                release_i,
  input  logic                age_inc_i,
  input  logic                age_clr_i,
  input  logic                clr_all_i,
  output logic [NOTE_W-1:0]   note_o,
  output logic                gate_o,
  output logic [AGE_BITS-1:0] age_o
);

  logic [NOTE_W-1:0]   note_q, note_d;
  logic                gate_q, gate_d;
  logic [AGE_BITS-1:0] age_q, age_d;

  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    age_d  = age_q;
    if (clr_all_i) begin
      // Panic keeps the note so any release tail retains its pitch.
      gate_d = 1'b0;
      age_d  = '0;
    end else begin
      if (load_i) begin
        note_d = load_note_i;
        gate_d = load_gate_i;
      end else if (release_i) begin
        gate_d = 1'b0;
      end
      if (age_clr_i) begin
        age_d = '0;
      end else if (age_inc_i && (age_q != {AGE_BITS{1'b1}})) begin
        age_d = age_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      note_q <= '0;
      gate_q <= 1'b0;
      age_q  <= '0;
    end else begin
      note_q <= note_d;
      gate_q <= gate_d;
      age_q  <= age_d;
    end
  end

  assign note_o = note_q;
  assign gate_o = gate_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential slot scan, oldest-voice stealing with a
// one-cycle retrigger gap. Stealing is enabled by defining VOICE_ALLOC_STEAL_EN.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_BITS   = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               ev_valid_i,
  output logic                               ev_ready_o,
  input  logic                               ev_note_on_i,
  input  logic [NOTE_W-1:0]                  ev_note_i,
  input  logic                               panic_i,
  output logic [NUM_VOICES*VOICE_NOTE_W-1:0] voice_note_o,
  output logic [NUM_VOICES-1:0]              voice_gate_o,
  output logic                               steal_o,
  output logic                               drop_o
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);

  alloc_state_e state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                on_q, on_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                match_vld_q, match_vld_d;
  logic [IdxW-1:0]     match_idx_q, match_idx_d;
  logic                free_vld_q, free_vld_d;
  logic [IdxW-1:0]     free_idx_q, free_idx_d;
  logic                old_vld_q, old_vld_d;
  logic [IdxW-1:0]     old_idx_q, old_idx_d;
  logic [AGE_BITS-1:0] old_age_q, old_age_d;
  logic [NUM_VOICES-1:0] off_mask_q, off_mask_d;
  // Carries steal with stealing enabled, drop otherwise.
  logic                pulse_q, pulse_d;

  logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
  logic [AGE_BITS-1:0]   slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;

  logic [NUM_VOICES-1:0] load, load_gate, rel, age_inc, age_clr, tgt_oh;
  logic [NOTE_W-1:0]     cur_note;
  logic                  cur_gate;
  logic [AGE_BITS-1:0]   cur_age;

  assign ev_ready_o = (state_q == StIdle) && !panic_i;

  assign cur_note = slot_note[idx_q];
  assign cur_gate = slot_gate[idx_q];
  assign cur_age  = slot_age[idx_q];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    off_mask_d  = off_mask_q;
    pulse_d     = 1'b0;
    load        = '0;
    load_gate   = '0;
    rel         = '0;
    age_inc     = '0;
    age_clr     = '0;
    tgt_oh      = '0;

    unique case (state_q)
      StIdle: begin
        if (ev_valid_i && ev_ready_o) begin
          on_d        = ev_note_on_i;
          note_d      = ev_note_i;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
          old_age_d   = '0;
          off_mask_d  = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (cur_gate && (cur_note == note_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!cur_gate && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict compare keeps the lower index on equal ages.
        if (cur_gate && (!old_vld_q || (cur_age > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = cur_age;
        end
        if ((on_q == EV_OFF) && cur_gate && (cur_note == note_q)) begin
          off_mask_d[idx_q] = 1'b1;
        end
        if (idx_q == IdxW'(NUM_VOICES - 1)) begin
          state_d = StCommit;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StCommit: begin
        state_d = StIdle;
        unique case (on_q)
          EV_ON: begin
            if (match_vld_q) begin
              tgt_oh[match_idx_q] = 1'b1;
              age_clr             = tgt_oh;
              age_inc             = slot_gate & ~tgt_oh;
            end else if (free_vld_q) begin
              tgt_oh[free_idx_q] = 1'b1;
              load               = tgt_oh;
              load_gate          = tgt_oh;
              age_clr            = tgt_oh;
              age_inc            = slot_gate & ~tgt_oh;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
              // Gate forced low now; RETRIG raises it for a fresh ADSR edge.
              tgt_oh[old_idx_q] = 1'b1;
              load              = tgt_oh;
              age_clr           = tgt_oh;
              age_inc           = slot_gate & ~tgt_oh;
              pulse_d           = 1'b1;
              state_d           = StRetrig;
`else
              pulse_d = 1'b1;
`endif
            end
          end
          EV_OFF: begin
            rel = off_mask_q;
          end
        endcase
      end
      StRetrig: begin
        tgt_oh[old_idx_q] = 1'b1;
        load              = tgt_oh;
        load_gate         = tgt_oh;
        age_clr           = tgt_oh;
        state_d           = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Slot commands are overridden inside each slot by clr_all.
    if (panic_i) begin
      state_d = StIdle;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      off_mask_q  <= '0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      off_mask_q  <= off_mask_d;
      pulse_q     <= pulse_d;
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  assign steal_o = pulse_q;
  assign drop_o  = 1'b0;
`else
  assign steal_o = 1'b0;
  assign drop_o  = pulse_q;
`endif

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .AGE_BITS(AGE_BITS)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (load[i]),
      .load_note_i(note_q),
      .load_gate_i(load_gate[i]),
      .release_i  (rel[i]),
      .age_inc_i  (age_inc[i]),
      .age_clr_i  (age_clr[i]),
      .clr_all_i  (panic_i),
      .note_o     (slot_note[i]),
      .gate_o     (slot_gate[i]),
      .age_o      (slot_age[i])
    );
    assign voice_note_o[i*VOICE_NOTE_W +: VOICE_NOTE_W] = {1'b0, slot_note[i]};
  end

  assign voice_gate_o = slot_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: driver pushes model predictions, monitor
// pops them each time ev_ready rises again (event completion).
module tb_voice_allocator;
  import voice_alloc_pkg::*;

  localparam int N       = 4;
  localparam int AGE_MAX = 255;

  logic           clk_i        = 1'b0;
  logic           rst_ni       = 1'b0;
  logic           ev_valid_i   = 1'b0;
  logic           ev_note_on_i = 1'b0;
  logic [6:0]     ev_note_i    = '0;
  logic           panic_i      = 1'b0;
  logic           ev_ready_o, steal_o, drop_o;
  logic [N*8-1:0] voice_note_o;
  logic [N-1:0]   voice_gate_o;

  always #5 clk_i = ~clk_i;

  voice_allocator #(
    .NUM_VOICES(N),
    .AGE_BITS  (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ev_valid_i  (ev_valid_i),
    .ev_ready_o  (ev_ready_o),
    .ev_note_on_i(ev_note_on_i),
    .ev_note_i   (ev_note_i),
    .panic_i     (panic_i),
    .voice_note_o(voice_note_o),
    .voice_gate_o(voice_gate_o),
    .steal_o     (steal_o),
    .drop_o      (drop_o)
  );

  typedef struct {
    bit             steal;
    bit             drop;
    bit             panic;
    int             slot;
    logic [N-1:0]   gate;
    logic [N*8-1:0] notes;
    logic [N-1:0]   falls;
    int             low;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b1;

  int m_note[N];
  bit m_gate[N];
  int m_age[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void fill_state(inout exp_t e);
    for (int i = 0; i < N; i++) begin
      e.gate[i]        = m_gate[i];
      e.notes[i*8 +: 8] = 8'(m_note[i]);
    end
  endfunction

  // Reference model: applies one event using the allocation rules directly.
  function automatic exp_t model_event(input bit on, input int note);
    exp_t e;
    int m, f, o, t;
    e = '{default: 0};
    e.slot = -1;
    e.low  = N + 1;
    m = -1; f = -1; o = -1; t = -1;
    if (on) begin
      for (int i = 0; i < N; i++) begin
        if (m_gate[i] && m_note[i] == note && m < 0) m = i;
        if (!m_gate[i] && f < 0) f = i;
        if (m_gate[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
      end
      if (m >= 0) t = m;
      else if (f >= 0) t = f;
      else begin
`ifdef VOICE_ALLOC_STEAL_EN
        t = o; e.steal = 1; e.slot = o; e.low = N + 2; e.falls[o] = 1'b1;
`else
        e.drop = 1;
`endif
      end
      if (t >= 0) begin
        for (int i = 0; i < N; i++)
          if (m_gate[i] && i != t && m_age[i] < AGE_MAX) m_age[i]++;
        m_age[t] = 0; m_gate[t] = 1; m_note[t] = note;
      end
    end else begin
      for (int i = 0; i < N; i++)
        if (m_gate[i] && m_note[i] == note) begin m_gate[i] = 0; e.falls[i] = 1'b1; end
    end
    fill_state(e);
    return e;
  endfunction

  function automatic exp_t model_panic();
    exp_t e;
    e = '{default: 0};
    e.panic = 1; e.slot = -1;
    for (int i = 0; i < N; i++) begin
      e.falls[i] = m_gate[i]; m_gate[i] = 0; m_age[i] = 0;
    end
    fill_state(e);
    return e;
  endfunction

  // Called just after a posedge; returns just after the acceptance edge.
  task automatic send(input bit on, input int note, input bit keep, input bit abort);
    exp_t e;
    int guard = 0;
    while (!ev_ready_o) begin
      @(posedge clk_i); #1;
      guard++;
      if (guard > 50) begin
        n_chk++; n_fail++;
        $display("FAIL ready_timeout: actual ev_ready 0 required 1 (t=%0t)", $time);
        return;
      end
    end
    ev_valid_i = 1'b1; ev_note_on_i = on; ev_note_i = 7'(note);
    if (!abort) begin
      e = model_event(on, note);
      exp_q.push_back(e);
    end
    @(posedge clk_i); #1;
    if (!keep) ev_valid_i = 1'b0;
  endtask

  logic [N-1:0] prev_gate = '0;
  logic [N-1:0] falls     = '0;
  bit           prev_rdy  = 1'b1;
  int           low_cnt = 0, nst = 0, ndr = 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        falls = falls | (prev_gate & ~voice_gate_o);
        if (steal_o) begin
          nst++;
          if (exp_q.size() > 0 && exp_q[0].steal) begin
            chk("steal_gate_low", 64'(voice_gate_o[exp_q[0].slot]), 64'd0);
            chk("steal_note", 64'(voice_note_o[exp_q[0].slot*8 +: 8]),
                64'(exp_q[0].notes[exp_q[0].slot*8 +: 8]));
          end
        end
        if (drop_o) ndr++;
        if (!ev_ready_o) low_cnt++;
        if (ev_ready_o && !prev_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("gates", 64'(voice_gate_o), 64'(e.gate));
            chk("notes", 64'(voice_note_o), 64'(e.notes));
            chk("steal_pulses", 64'(nst), 64'(e.steal));
            chk("drop_pulses", 64'(ndr), 64'(e.drop));
            chk("gate_falls", 64'(falls), 64'(e.falls));
            if (!e.panic) chk("ready_low_cycles", 64'(low_cnt), 64'(e.low));
          end
          low_cnt = 0; nst = 0; ndr = 0; falls = '0;
        end
      end
      prev_gate = voice_gate_o;
      prev_rdy  = ev_ready_o;
    end
  end

  initial begin : driver
    exp_t e;
    int   guard;
    for (int i = 0; i < N; i++) begin m_note[i] = 0; m_gate[i] = 0; m_age[i] = 0; end
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ready", 64'(ev_ready_o), 64'd1);
    chk("reset_gates", 64'(voice_gate_o), 64'd0);
    chk("reset_notes", 64'(voice_note_o), 64'd0);
    chk("reset_steal_drop", 64'({steal_o, drop_o}), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Basic allocation, then fill and overflow.
    send(EV_ON, 60, 0, 0); send(EV_ON, 64, 0, 0); send(EV_ON, 67, 0, 0);
    send(EV_ON, 65, 0, 0); send(EV_ON, 72, 0, 0);

    // Panic once mid-scan, once with COMMIT pending.
    for (int k = 0; k < 2; k++) begin
      send(EV_ON, 70 + k, 0, 1);
      repeat ((k == 0) ? 2 : 4) @(posedge clk_i);
      #1;
      panic_i = 1'b1;
      e = model_panic();
      exp_q.push_back(e);
      chk("panic_ready_low", 64'(ev_ready_o), 64'd0);
      @(posedge clk_i); #1;
      chk("panic_gates_clear", 64'(voice_gate_o), 64'd0);
      chk("panic_ready_low_held", 64'(ev_ready_o), 64'd0);
      panic_i = 1'b0;
      @(posedge clk_i); #1;
    end

    // Match refresh reorders ages so the later overflow targets slot 1.
    send(EV_ON, 60, 0, 0); send(EV_ON, 62, 0, 0); send(EV_ON, 64, 0, 0);
    send(EV_ON, 65, 0, 0); send(EV_ON, 60, 0, 0); send(EV_ON, 72, 0, 0);
    send(EV_OFF, 72, 0, 0); send(EV_OFF, 50, 0, 0);

    // Back-to-back with ev_valid held high.
    send(EV_ON, 40, 1, 0); send(EV_ON, 41, 1, 0); send(EV_OFF, 40, 1, 0);
    send(EV_ON, 42, 0, 0);

    for (int k = 0; k < 80; k++) begin
      send(($urandom_range(0, 99) < 65) ? EV_ON : EV_OFF, 60 + $urandom_range(0, 7),
           $urandom_range(0, 1), 0);
    end
    ev_valid_i = 1'b0;

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk_i); guard++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;

    // Reset mid-scan aborts the event.
    mon_en = 1'b0;
    send(EV_ON, 61, 0, 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #2;
    chk("midscan_reset_ready", 64'(ev_ready_o), 64'd1);
    chk("midscan_reset_gates", 64'(voice_gate_o), 64'd0);
    chk("midscan_reset_notes", 64'(voice_note_o), 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator feeding a bank of `voice` instances. Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of `NUM_VOICES` voice slots. Each slot drives one voice's `midi_data` and `enable` (gate) inputs. Allocation uses a sequential slot scan with oldest-voice stealing and retrigger-gap generation, so the downstream ADSR sees a fresh gate edge.

## Interface
- `NUM_VOICES`, 4: number of voice slots; must be ≥2.
- `AGE_BITS`, 8: width of the per-slot age counter.
- `clk` in 1: system clock, the same one that clocks the voices.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ev_valid` in 1: event present.
- `ev_ready` out 1: allocator can accept an event; high only in IDLE.
- `ev_note_on` in 1: 1 = note-on, 0 = note-off.
- `ev_note` in 7: MIDI note number.
- `panic` in 1: all-notes-off, synchronous, level-sampled.
- `voice_note` out `NUM_VOICES*8`: slot i at bits [8i+7:8i], `{1'b0, note}`; connects to voice `midi_data`.
- `voice_gate` out `NUM_VOICES`: bit i connects to voice i `enable`.
- `steal` out 1: one-cycle pulse when a gated slot is stolen.
- `drop` out 1: one-cycle pulse when a note-on is discarded.

## Operation
- States: IDLE, SCAN, COMMIT, RETRIG.
- IDLE:
  - `ev_valid && ev_ready` latches `ev_note_on` and `ev_note`.
  - Clears the scan index and the candidates.
  - Goes to SCAN.
- SCAN: evaluates one slot per cycle, index 0..`NUM_VOICES-1`, then goes to COMMIT. It tracks three candidates:
  - `match`: the first gated slot holding the latched note.
  - `free`: the first slot with gate = 0.
  - `oldest`: the gated slot with the largest age; ties go to the lower index.
  - Note-off additionally collects a mask of every gated slot whose note equals the latched note.
- COMMIT, note-on, first applicable rule wins:
  - `match` found: that slot's age is cleared; gate and note are unchanged. Go to IDLE.
  - `free` found: write the note, set gate = 1, clear age. Go to IDLE.
  - Otherwise steal `oldest`: write the note, force gate = 0, pulse `steal`. Go to RETRIG.
- COMMIT, note-off:
  - Every slot in the mask gets gate = 0. The note is retained so the release tail keeps its pitch.
  - An empty mask is ignored silently. Go to IDLE.
- RETRIG: stolen slot gate = 1, age cleared. Go to IDLE.
- Aging: on every note-on COMMIT, every gated slot other than the assigned one increments its age, saturating at 2^`AGE_BITS`-1. Ungated slots keep their age.
- `panic`:
  - Highest priority. The next edge clears all gates and ages and forces IDLE.
  - An in-flight event is discarded with no `steal` or `drop` pulse.
  - Notes are retained.
  - `ev_ready` is low while `panic` is high.
- Reset: state IDLE, all `voice_gate` = 0, all `voice_note` = 0, ages = 0, `steal` = `drop` = 0, `ev_ready` = 1. Asserting reset mid-scan aborts the event.

## Timing
- Acceptance edge E0. SCAN occupies edges E1..E`NUM_VOICES`. COMMIT is edge E`NUM_VOICES+1`.
- `voice_note` and `voice_gate` change at COMMIT. Latency is `NUM_VOICES+1` cycles from acceptance.
- Steal: gate is low for exactly one cycle (COMMIT→RETRIG) and rises at edge E`NUM_VOICES+2`.
- `ev_ready` is 0 from E0 until the state returns to IDLE. Maximum throughput is one event per `NUM_VOICES+2` cycles, or `NUM_VOICES+3` with a steal.
- `ev_ready` is a function of registered state and `panic` only. It has no combinational path from `ev_valid`.
- `steal` and `drop` are registered and high for the single cycle after COMMIT.

## Configuration
- `VOICE_ALLOC_STEAL_EN` defined: stealing behaves as in Operation.
- `VOICE_ALLOC_STEAL_EN` undefined:
  - A note-on with no `match` and no `free` slot is discarded, `drop` pulses, and the FSM goes to IDLE.
  - RETRIG is unreachable; `steal` is tied 0.
  - Age tracking remains, for `match` refresh only.
- With the macro defined, `drop` is tied 0.

## Structure
- Package `voice_alloc_pkg`: state enum type, `NOTE_W = 7`, `VOICE_NOTE_W = 8`, and event-type constants `EV_OFF = 0`, `EV_ON = 1`.
- Sub-module `voice_slot`, one instance per voice, holds note, gate, and age. Its commands:
  - `load`: note and gate.
  - `release`.
  - `age_inc` (saturating).
  - `age_clr`.
  - `clr_all` (panic).
- The top level holds the FSM, scan index, and candidate registers.

## Test plan
- Reset, then note-on 60, 64, 67 → slots 0, 1, 2 gated with notes 0x3C, 0x40, 0x43. Each write lands 5 cycles after acceptance (`NUM_VOICES` = 4).
- Fill 4 slots with notes 60, 62, 64, 65, then note-on 72 → slot 0 note 0x48; gate low for one cycle, then high; `steal` pulses once. Without `VOICE_ALLOC_STEAL_EN`: `drop` pulses and the slots are unchanged.
- Note-on 60 twice → only slot 0 is used, with no gate glitch. The second event clears its age, so a later steal picks slot 1.
- Note-on 60 twice with a forced duplicate in slots 0 and 2 (via panic-free preload sequence), then note-off 60 → both gates low, notes still 0x3C. Note-off 50 → no change.
- `panic` asserted during SCAN → next edge all gates 0, state IDLE, no `steal`/`drop` pulse; `ev_ready` is low while `panic` is high.
- Hold `ev_valid` high across back-to-back events → exactly one acceptance per `ev_ready` high cycle, and `ev_ready` low for 5 cycles after each acceptance.
